// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: data-cache address view, frame layout and controller states.
package cpu_types_pkg;

    localparam int DSETS  = 8;
    localparam int DWORDS = 2;

    typedef struct packed {
        logic [25:0] tag;
        logic [2:0]  idx;
        logic        blkoff;
        logic [1:0]  bytoff;
    } dcachef_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [25:0]      tag;
        logic [1:0][31:0] data;
    } dcache_frame;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FSCAN,
        FWB0,
        FWB1,
        DONE
    } dcache_state_t;

endpackage

// File: rtl/dcache.sv
// 2-way set-associative, write-back/write-allocate data cache with an LL/SC
// link register and a halt-triggered flush of dirty blocks.
//
// state | meaning
// IDLE  | combinational hit check, serve hits, pick victim on miss
// WB0   | write victim word 0 back to memory
// WB1   | write victim word 1 back to memory
// LD0   | fetch requested block word 0 into victim way
// LD1   | fetch word 1, validate frame, return to IDLE
// FSCAN | inspect one (set, way) of the flush scan per cycle
// FWB0  | flush: write dirty word 0
// FWB1  | flush: write dirty word 1, clear dirty, advance scan
// DONE  | flush complete; requests ignored until reset
module dcache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = DSETS,
    parameter int WORDS = DWORDS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

    localparam int             IW        = $clog2(SETS);
    localparam logic           LAST_WORD = 1'(WORDS - 1);
    localparam logic [IW-1:0]  LAST_SET  = IW'(SETS - 1);

    dcache_state_t state_q, state_d;
    dcache_frame   frame_q [2][SETS];
    logic [SETS-1:0] lru_q;
    logic          victim_q, victim_d;
    logic [IW-1:0] fset_q, fset_d;
    logic          fway_q, fway_d;
    logic          link_valid_q;
    logic [31:0]   link_addr_q;

    dcachef_t    req;
    dcache_frame fr0, fr1, hit_fr, vic_fr, fl_fr;
    logic        hit0, hit1, hit, hit_way, vsel, link_hit, flush_last;
    logic        wr_hit, lru_upd, link_set, link_clr, ld_we, ld_word, ld_fill, fl_clean;
    logic        unused_bytoff;

    assign req           = dcachef_t'(dmemaddr);
    assign unused_bytoff = ^req.bytoff;

    assign fr0      = frame_q[0][req.idx];
    assign fr1      = frame_q[1][req.idx];
    assign hit0     = fr0.valid && (fr0.tag == req.tag);
    assign hit1     = fr1.valid && (fr1.tag == req.tag);
    assign hit      = hit0 || hit1;
    assign hit_way  = !hit0;
    assign hit_fr   = hit_way ? fr1 : fr0;
    assign vsel     = !fr0.valid ? 1'b0 : (!fr1.valid ? 1'b1 : lru_q[req.idx]);
    assign vic_fr   = frame_q[victim_q][req.idx];
    assign fl_fr    = frame_q[fway_q][fset_q];
    assign link_hit = link_valid_q && (link_addr_q == dmemaddr);
    assign flush_last = (fset_q == LAST_SET) && fway_q;

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        fset_d   = fset_q;
        fway_d   = fway_q;
        dhit     = 1'b0;
        dmemload = '0;
        flushed  = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        wr_hit   = 1'b0;
        lru_upd  = 1'b0;
        link_set = 1'b0;
        link_clr = 1'b0;
        ld_we    = 1'b0;
        ld_word  = 1'b0;
        ld_fill  = 1'b0;
        fl_clean = 1'b0;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FSCAN;
                    fset_d  = '0;
                    fway_d  = 1'b0;
                end else if (dmemWEN || dmemREN) begin
                    if (datomic && dmemWEN && !link_hit) begin
                        // failed SC answers immediately, touching neither cache nor memory
                        dhit = 1'b1;
                    end else if (hit) begin
                        dhit    = 1'b1;
                        lru_upd = 1'b1;
                        if (dmemWEN) begin
                            wr_hit = 1'b1;
                            if (datomic) begin
                                dmemload = 32'd1;
                                link_clr = 1'b1;
                            end else begin
                                link_clr = link_hit;
                            end
                        end else begin
                            dmemload = hit_fr.data[req.blkoff];
                            link_set = datomic;
                        end
                    end else begin
                        victim_d = vsel;
                        state_d  = (frame_q[vsel][req.idx].valid && frame_q[vsel][req.idx].dirty)
                                   ? WB0 : LD0;
                    end
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {vic_fr.tag, req.idx, 1'b0, 2'b00};
                dstore = vic_fr.data[0];
                if (!dwait) state_d = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {vic_fr.tag, req.idx, LAST_WORD, 2'b00};
                dstore = vic_fr.data[LAST_WORD];
                if (!dwait) state_d = LD0;
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = {req.tag, req.idx, 1'b0, 2'b00};
                if (!dwait) begin
                    ld_we   = 1'b1;
                    state_d = LD1;
                end
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = {req.tag, req.idx, LAST_WORD, 2'b00};
                if (!dwait) begin
                    ld_we   = 1'b1;
                    ld_word = LAST_WORD;
                    ld_fill = 1'b1;
                    state_d = IDLE;
                end
            end
            FSCAN: begin
                if (fl_fr.valid && fl_fr.dirty) begin
                    state_d = FWB0;
                end else if (flush_last) begin
                    state_d = DONE;
                end else begin
                    {fset_d, fway_d} = {fset_q, fway_q} + (IW + 1)'(1);
                end
            end
            FWB0: begin
                dWEN   = 1'b1;
                daddr  = {fl_fr.tag, fset_q, 1'b0, 2'b00};
                dstore = fl_fr.data[0];
                if (!dwait) state_d = FWB1;
            end
            FWB1: begin
                dWEN   = 1'b1;
                daddr  = {fl_fr.tag, fset_q, LAST_WORD, 2'b00};
                dstore = fl_fr.data[LAST_WORD];
                if (!dwait) begin
                    fl_clean = 1'b1;
                    if (flush_last) begin
                        state_d = DONE;
                    end else begin
                        state_d          = FSCAN;
                        {fset_d, fway_d} = {fset_q, fway_q} + (IW + 1)'(1);
                    end
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= IDLE;
            victim_q     <= 1'b0;
            fset_q       <= '0;
            fway_q       <= 1'b0;
            lru_q        <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                frame_q[0][s] <= '0;
                frame_q[1][s] <= '0;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            fset_q   <= fset_d;
            fway_q   <= fway_d;

            if (lru_upd) lru_q[req.idx] <= !hit_way;

            if (link_set) begin
                link_valid_q <= 1'b1;
                link_addr_q  <= dmemaddr;
            end else if (link_clr) begin
                link_valid_q <= 1'b0;
            end

            if (wr_hit) begin
                frame_q[hit_way][req.idx].data[req.blkoff] <= dmemstore;
                frame_q[hit_way][req.idx].dirty            <= 1'b1;
            end

            if (ld_we) frame_q[victim_q][req.idx].data[ld_word] <= dload;
            if (ld_fill) begin
                frame_q[victim_q][req.idx].valid <= 1'b1;
                frame_q[victim_q][req.idx].dirty <= 1'b0;
                frame_q[victim_q][req.idx].tag   <= req.tag;
            end

            if (fl_clean) frame_q[fway_q][fset_q].dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: directed requests push expected hits and memory
// transfers; negedge monitors pop and compare.
module tb_dcache;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, datomic, halt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic        dhit, flushed, dREN, dWEN;
    logic [31:0] dmemload, daddr, dstore;

    typedef struct {
        logic        chk;
        logic [31:0] data;
    } hexp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mexp_t;

    hexp_t       hit_q[$];
    mexp_t       mem_q[$];
    logic [31:0] mem [logic [31:0]];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_wr = 0;

    dcache dut (
        .CLK(CLK), .nRST(nRST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .datomic(datomic),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload)
    );

    always #5 CLK = ~CLK;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {16'hD00D, a[15:0]};
    endfunction

    function automatic void push_rd(input logic [31:0] a);
        mem_q.push_back('{we: 1'b0, addr: a, data: 32'h0});
    endfunction

    function automatic void push_wr(input logic [31:0] a, input logic [31:0] d);
        mem_q.push_back('{we: 1'b1, addr: a, data: d});
    endfunction

    // memory model and both monitors; transfers complete at the following posedge
    always @(negedge CLK) begin
        hexp_t h;
        mexp_t m;
        if (nRST && (dREN || dWEN) && !dwait) begin
            if (mem_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL mem_unexpected: got ren=%0b wen=%0b addr=0x%08h, expected no transfer", dREN, dWEN, daddr);
            end else begin
                m = mem_q.pop_front();
                check("mem_we", {31'b0, dWEN}, {31'b0, m.we});
                check("mem_addr", daddr, m.addr);
                if (m.we) check("mem_wdata", dstore, m.data);
            end
            if (dWEN) begin
                mem[daddr] = dstore;
                n_wr++;
            end
        end
        if (nRST && dhit && (dmemREN || dmemWEN)) begin
            if (hit_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL hit_unexpected: got dhit=1 addr=0x%08h, expected no hit", dmemaddr);
            end else begin
                h = hit_q.pop_front();
                if (h.chk) check("hit_data", dmemload, h.data);
            end
        end
        dload = rd_mem(daddr);
    end

    task automatic do_req(input logic we, input logic re, input logic at, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                          input int exp_lat);
        int  lat;
        bit  done;
        hit_q.push_back('{chk: chk, data: exp});
        dmemWEN = we; dmemREN = re; datomic = at; dmemaddr = addr; dmemstore = wdata;
        lat  = 0;
        done = 0;
        while (!done) begin
            @(negedge CLK);
            if (dhit) begin
                done = 1;
            end else begin
                lat++;
                if (lat > 200) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL req_timeout addr=0x%08h: got no dhit in %0d cycles, expected dhit=1", addr, lat);
                    done = 1;
                end
            end
        end
        if (exp_lat >= 0) check("hit_latency", 32'(lat), 32'(exp_lat));
        @(posedge CLK);
        #1;
        dmemWEN = 1'b0; dmemREN = 1'b0; datomic = 1'b0;
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, "_dhit"}, {31'b0, dhit}, 32'h0);
        check({nm, "_dmemload"}, dmemload, 32'h0);
        check({nm, "_flushed"}, {31'b0, flushed}, 32'h0);
        check({nm, "_dren"}, {31'b0, dREN}, 32'h0);
        check({nm, "_dwen"}, {31'b0, dWEN}, 32'h0);
        check({nm, "_daddr"}, daddr, 32'h0);
        check({nm, "_dstore"}, dstore, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wr0;
        int  cyc;
        nRST = 1'b0; dmemREN = 0; dmemWEN = 0; datomic = 0; halt = 0; dwait = 0;
        dmemaddr = '0; dmemstore = '0; dload = '0;
        mem[32'h40] = 32'h0000AAAA;
        mem[32'h44] = 32'h0000BBBB;
        repeat (2) @(negedge CLK);
        check_idle_outputs("reset");
        @(posedge CLK); #1;
        nRST = 1'b1;

        // cold read, then same-block hit
        push_rd(32'h40); push_rd(32'h44);
        do_req(0, 1, 0, 32'h40, 0, 1, 32'h0000AAAA, 3);
        do_req(0, 1, 0, 32'h44, 0, 1, 32'h0000BBBB, 0);

        // dirty line evicted by two conflicting tags in set 0
        do_req(1, 0, 0, 32'h40, 32'h12345678, 0, 0, 0);
        push_rd(32'h440); push_rd(32'h444);
        do_req(0, 1, 0, 32'h440, 0, 1, 32'hD00D0440, 3);
        push_wr(32'h40, 32'h12345678); push_wr(32'h44, 32'h0000BBBB);
        push_rd(32'h840); push_rd(32'h844);
        do_req(0, 1, 0, 32'h840, 0, 1, 32'hD00D0840, 5);

        // LL / SC success
        push_rd(32'h80); push_rd(32'h84);
        do_req(0, 1, 1, 32'h80, 0, 1, 32'hD00D0080, 3);
        do_req(1, 0, 1, 32'h80, 32'h5, 1, 32'h1, 0);
        do_req(0, 1, 0, 32'h80, 0, 1, 32'h5, 0);

        // LL broken by an intervening plain write; SC fails without side effects
        do_req(0, 1, 1, 32'h80, 0, 1, 32'h5, 0);
        do_req(1, 0, 0, 32'h80, 32'h77, 0, 0, 0);
        do_req(1, 0, 1, 32'h80, 32'h9, 1, 32'h0, 0);
        do_req(0, 1, 0, 32'h80, 0, 1, 32'h77, 0);

        // reset in the middle of a stalled LD0
        dwait = 1'b1;
        dmemREN = 1'b1; dmemaddr = 32'h100;
        repeat (3) @(posedge CLK);
        #1;
        check("ld0_dren", {31'b0, dREN}, 32'h1);
        check("ld0_daddr", daddr, 32'h100);
        nRST = 1'b0; dmemREN = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge CLK); #1;
        nRST = 1'b1; dwait = 1'b0;
        push_rd(32'h100); push_rd(32'h104);
        do_req(0, 1, 0, 32'h100, 0, 1, 32'hD00D0100, 3);

        // three dirty blocks in sets 1, 4, 7 then flush
        push_rd(32'h08); push_rd(32'h0C);
        do_req(1, 0, 0, 32'h08, 32'h1111, 0, 0, 3);
        push_rd(32'h20); push_rd(32'h24);
        do_req(1, 0, 0, 32'h20, 32'h4444, 0, 0, 3);
        push_rd(32'h38); push_rd(32'h3C);
        do_req(1, 0, 0, 32'h38, 32'h7777, 0, 0, 3);
        push_wr(32'h08, 32'h1111); push_wr(32'h0C, 32'hD00D000C);
        push_wr(32'h20, 32'h4444); push_wr(32'h24, 32'hD00D0024);
        push_wr(32'h38, 32'h7777); push_wr(32'h3C, 32'hD00D003C);
        wr0  = n_wr;
        halt = 1'b1;
        cyc  = 0;
        while (!flushed && cyc < 200) begin
            @(negedge CLK);
            cyc++;
        end
        check("flushed_set", {31'b0, flushed}, 32'h1);
        check("flush_wr_count", 32'(n_wr - wr0), 32'd6);
        @(posedge CLK); #1;
        dmemREN = 1'b1; dmemaddr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("done_flushed", {31'b0, flushed}, 32'h1);
            check("done_dhit", {31'b0, dhit}, 32'h0);
            check("done_mem", {30'b0, dREN, dWEN}, 32'h0);
        end
        dmemREN = 1'b0;

        check("hit_q_drained", 32'(hit_q.size()), 32'h0);
        check("mem_q_drained", 32'(mem_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
